// File: rtl/sprite_line_pkg.sv
// Shared types and constants for the double-banked scanline sprite engine.
package sprite_line_pkg;

  localparam logic [3:0] REG_ENTRY = 4'd0;
  localparam logic [3:0] REG_CTRL  = 4'd1;
  localparam logic [3:0] REG_CLR   = 4'd2;

  localparam int ENTRY_X_LSB    = 0;
  localparam int ENTRY_Y_LSB    = 10;
  localparam int ENTRY_ID_LSB   = 20;
  localparam int ENTRY_IDX_LSB  = 26;
  localparam int COORD_BITS     = 10;
  localparam int FIELD_ID_BITS  = 6;
  localparam int FIELD_IDX_BITS = 6;

  // Last cycle of a 1600-clock scanline; the render must be idle by then.
  localparam int LAST_HCOUNT = 1599;

  typedef struct packed {
    logic [FIELD_ID_BITS-1:0] id;
    logic [COORD_BITS-1:0]    y;
    logic [COORD_BITS-1:0]    x;
  } sprite_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_CHECK,
    ST_DRAW,
    ST_DRAIN
  } line_state_t;

  function automatic sprite_entry_t unpack_entry(input logic [ENTRY_IDX_LSB-1:0] word);
    sprite_entry_t e;
    e.x  = word[ENTRY_X_LSB +: COORD_BITS];
    e.y  = word[ENTRY_Y_LSB +: COORD_BITS];
    e.id = word[ENTRY_ID_LSB +: FIELD_ID_BITS];
    return e;
  endfunction

endpackage

// File: rtl/sprite_table_banks.sv
// Two sprite-table banks: host writes the back bank, renderer reads the active one.
// The banks swap at the vblank point when a commit is pending.
module sprite_table_banks
  import sprite_line_pkg::*;
#(
  parameter  int NUM_SPRITES = 64,
  localparam int IDX_W       = $clog2(NUM_SPRITES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  sprite_entry_t wr_entry,
  input  logic          commit_req,
  input  logic          swap_point,
  input  logic [IDX_W-1:0] rd_index,
  output sprite_entry_t rd_entry,
  output logic          rd_valid
);

  logic                   active_bank;
  logic                   commit_pending;
  logic [NUM_SPRITES-1:0] valid_q [2];
  sprite_entry_t          mem [2*NUM_SPRITES];

  logic swap;
  logic back_bank;

  assign swap      = swap_point && commit_pending;
  // During a swap the old active bank becomes the back bank, so a coincident write lands there.
  assign back_bank = swap ? active_bank : ~active_bank;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_bank    <= 1'b0;
      commit_pending <= 1'b0;
      valid_q[0]     <= '0;
      valid_q[1]     <= '0;
      rd_valid       <= 1'b0;
    end else begin
      if (swap) begin
        active_bank          <= ~active_bank;
        valid_q[active_bank] <= '0;
      end
      if (commit_req)
        commit_pending <= 1'b1;
      else if (swap)
        commit_pending <= 1'b0;
      if (wr_en)
        valid_q[back_bank][wr_index] <= 1'b1;
      rd_valid <= valid_q[active_bank][rd_index];
    end
  end

  // NOTE: table storage is RAM and deliberately has no reset; the valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[{back_bank, wr_index}] <= wr_entry;
    rd_entry <= mem[{active_bank, rd_index}];
  end

endmodule

// File: rtl/sprite_line_engine.sv
// Scanline sprite renderer with double-banked table and ping-pong line buffers.
// Define SPRITE_COLLISION_EN to add per-pixel ownership and the sticky collision flag.
module sprite_line_engine
  import sprite_line_pkg::*;
#(
  parameter int NUM_SPRITES  = 64,
  parameter int SPRITE_W     = 32,
  parameter int SPRITE_H     = 32,
  parameter int ID_BITS      = 6,
  parameter int COLOR_BITS   = 4,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int MAX_PER_LINE = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        chipselect,
  input  logic                        write,
  input  logic [3:0]                  address,
  input  logic [31:0]                 writedata,
  input  logic [10:0]                 hcount,
  input  logic [9:0]                  vcount,
  input  logic [COLOR_BITS-1:0]       bg_color,
  output logic [ID_BITS-1:0]          rom_id,
  output logic [$clog2(SPRITE_H)-1:0] rom_line,
  output logic [$clog2(SPRITE_W)-1:0] rom_pixel,
  input  logic [COLOR_BITS-1:0]       rom_color,
  output logic [COLOR_BITS-1:0]       pix_color,
  output logic                        line_overflow,
  output logic                        collision
);

  localparam int IDX_W        = $clog2(NUM_SPRITES);
  localparam int LINE_W       = $clog2(SPRITE_H);
  localparam int PIX_W        = $clog2(SPRITE_W);
  localparam int DRAWN_W      = $clog2(MAX_PER_LINE + 1);
  localparam int WORST_CYCLES = 1 + 2*NUM_SPRITES + MAX_PER_LINE*(SPRITE_W + 1);

  if (WORST_CYCLES > LAST_HCOUNT) begin : g_budget_check
    $error("sprite_line_engine: worst-case render does not fit in one scanline");
  end

  // Host register decode
  logic                      host_wr, entry_wr, commit_req, flag_clr, swap_point;
  logic [FIELD_IDX_BITS-1:0] wr_slot;

  assign host_wr    = chipselect && write;
  assign wr_slot    = writedata[ENTRY_IDX_LSB +: FIELD_IDX_BITS];
  assign entry_wr   = host_wr && (address == REG_ENTRY) && ({1'b0, wr_slot} < 7'(NUM_SPRITES));
  assign commit_req = host_wr && (address == REG_CTRL) && writedata[0];
  assign flag_clr   = host_wr && (address == REG_CLR);
  assign swap_point = (vcount == 10'(V_ACTIVE)) && (hcount == '0);

  line_state_t       state_q, state_d;
  logic [9:0]        tline;
  logic              wbuf;
  logic [IDX_W-1:0]  idx;
  logic [DRAWN_W-1:0] drawn;
  logic [9:0]        cur_x;
  logic              wr_pend;
  logic [10:0]       wr_x;

  sprite_entry_t table_entry;
  logic          table_valid;

  sprite_table_banks #(.NUM_SPRITES(NUM_SPRITES)) u_banks (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (entry_wr),
    .wr_index   (wr_slot[IDX_W-1:0]),
    .wr_entry   (unpack_entry(writedata[ENTRY_IDX_LSB-1:0])),
    .commit_req (commit_req),
    .swap_point (swap_point),
    .rd_index   (idx),
    .rd_entry   (table_entry),
    .rd_valid   (table_valid)
  );

  logic [9:0] target, dy;
  logic       start, abort, hit, budget_full, last_idx, pix_wr, disp_on;

  assign target      = (vcount == 10'(V_TOTAL - 1)) ? '0 : vcount + 10'd1;
  assign start       = (hcount == '0) && (target < 10'(V_ACTIVE));
  assign abort       = (state_q != ST_IDLE) && (hcount == 11'(LAST_HCOUNT));
  assign dy          = tline - table_entry.y;
  assign hit         = table_valid && (table_entry.id != '0) && (tline >= table_entry.y)
                       && (dy < 10'(SPRITE_H));
  assign budget_full = (drawn == DRAWN_W'(MAX_PER_LINE));
  assign last_idx    = (idx == IDX_W'(NUM_SPRITES - 1));
  assign pix_wr      = wr_pend && (rom_color != '0) && (wr_x < 11'(H_ACTIVE));
  assign disp_on     = (hcount < 11'(2*H_ACTIVE)) && (vcount < 10'(V_ACTIVE));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: next state gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_FETCH;
      ST_FETCH: state_d = ST_CHECK;
      ST_CHECK: begin
        if (hit && !budget_full) state_d = ST_DRAW;
        else                     state_d = last_idx ? ST_IDLE : ST_FETCH;
      end
      ST_DRAW:  if (rom_pixel == PIX_W'(SPRITE_W - 1)) state_d = ST_DRAIN;
      ST_DRAIN: state_d = last_idx ? ST_IDLE : ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      tline     <= '0;
      wbuf      <= 1'b0;
      idx       <= '0;
      drawn     <= '0;
      cur_x     <= '0;
      rom_id    <= '0;
      rom_line  <= '0;
      rom_pixel <= '0;
      wr_pend   <= 1'b0;
      wr_x      <= '0;
    end else begin
      // ROM data for the pixel issued this cycle arrives next cycle.
      wr_pend <= (state_q == ST_DRAW);
      wr_x    <= {1'b0, cur_x} + 11'(rom_pixel);
      unique case (state_q)
        ST_IDLE: if (start) begin
          tline <= target;
          wbuf  <= target[0];
        end
        ST_CLEAR: begin
          idx   <= '0;
          drawn <= '0;
        end
        ST_CHECK: begin
          if (hit && !budget_full) begin
            drawn     <= drawn + DRAWN_W'(1);
            cur_x     <= table_entry.x;
            rom_id    <= ID_BITS'(table_entry.id);
            rom_line  <= LINE_W'(dy);
            rom_pixel <= '0;
          end else if (!last_idx) begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DRAW:  rom_pixel <= rom_pixel + PIX_W'(1);
        ST_DRAIN: if (!last_idx) idx <= idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

  logic [COLOR_BITS-1:0] line_buf [2][H_ACTIVE];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < H_ACTIVE; i++)
          line_buf[b][i] <= '0;
      pix_color     <= '0;
      line_overflow <= 1'b0;
    end else begin
      if (state_q == ST_CLEAR)
        for (int i = 0; i < H_ACTIVE; i++)
          line_buf[wbuf][i] <= bg_color;
      if (pix_wr)
        line_buf[wbuf][wr_x[9:0]] <= rom_color;
      pix_color <= disp_on ? line_buf[vcount[0]][hcount[10:1]] : '0;
      if (flag_clr)
        line_overflow <= 1'b0;
      if (abort || (state_q == ST_CHECK && hit && budget_full))
        line_overflow <= 1'b1;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [H_ACTIVE-1:0] owned;

  always_ff @(posedge clk) begin
    if (reset) begin
      owned     <= '0;
      collision <= 1'b0;
    end else begin
      if (state_q == ST_CLEAR)
        owned <= '0;
      if (pix_wr)
        owned[wr_x[9:0]] <= 1'b1;
      if (flag_clr)
        collision <= 1'b0;
      if (pix_wr && owned[wr_x[9:0]])
        collision <= 1'b1;
    end
  end
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine: drives a behavioural sprite ROM and jumps
// hcount/vcount to render and inspect individual lines.
module tb_sprite_line_engine;

  logic        clk = 1'b0;
  logic        reset, chipselect, write;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [3:0]  bg_color, rom_color, pix_color;
  logic [5:0]  rom_id;
  logic [4:0]  rom_line, rom_pixel;
  logic        line_overflow, collision;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SPRITE_COLLISION_EN
  localparam logic EXP_COLL = 1'b1;
`else
  localparam logic EXP_COLL = 1'b0;
`endif

  always #10 clk = ~clk;

  sprite_line_engine dut (
    .clk           (clk),
    .reset         (reset),
    .chipselect    (chipselect),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .hcount        (hcount),
    .vcount        (vcount),
    .bg_color      (bg_color),
    .rom_id        (rom_id),
    .rom_line      (rom_line),
    .rom_pixel     (rom_pixel),
    .rom_color     (rom_color),
    .pix_color     (pix_color),
    .line_overflow (line_overflow),
    .collision     (collision)
  );

  // Sprite ROM: every fourth column transparent, others depend on id/row/column.
  function automatic logic [3:0] rom_fn(input int id, input int line, input int pix);
    if ((pix % 4) == 3) return 4'd0;
    return 4'((id + line + pix) % 15 + 1);
  endfunction

  always @(posedge clk) rom_color <= rom_fn(int'(rom_id), int'(rom_line), int'(rom_pixel));

  function automatic logic [31:0] entry_word(input int idx, input int id, input int y, input int x);
    return {6'(idx), 6'(id), 10'(y), 10'(x)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = addr; writedata = data;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic vblank_tick();
    @(negedge clk);
    vcount = 10'd480; hcount = 11'd0;
    @(negedge clk);
    hcount = 11'd1000;
  endtask

  task automatic render_line(input int line, input logic [3:0] bg);
    @(negedge clk);
    vcount = (line == 0) ? 10'd524 : 10'(line - 1);
    bg_color = bg;
    hcount = 11'd0;
    for (int h = 1; h < 760; h++) begin
      @(negedge clk);
      hcount = 11'(h);
    end
    @(negedge clk);
    hcount = 11'd1000;
  endtask

  task automatic read_px(input int line, input int px, output logic [3:0] v);
    @(negedge clk);
    vcount = 10'(line);
    hcount = 11'(2*px + 1);
    @(negedge clk);
    v = pix_color;
  endtask

  logic [3:0] v;

  initial begin
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
    hcount = 11'd1000; vcount = 10'd0; bg_color = '0;
    repeat (3) @(negedge clk);
    check("reset pix_color", 32'(pix_color), 32'd0);
    check("reset line_overflow", 32'(line_overflow), 32'd0);
    check("reset collision", 32'(collision), 32'd0);
    check("reset rom_id", 32'(rom_id), 32'd0);
    check("reset rom_pixel", 32'(rom_pixel), 32'd0);
    reset = 1'b0;

    // Single sprite id 5 at (100,50)
    host_write(4'd0, entry_word(0, 5, 50, 100));
    host_write(4'd1, 32'd1);
    vblank_tick();
    render_line(50, 4'd9);
    read_px(50, 99, v);  check("l50 px99 bg", 32'(v), 32'd9);
    read_px(50, 100, v); check("l50 px100", 32'(v), 32'(rom_fn(5, 0, 0)));
    read_px(50, 101, v); check("l50 px101", 32'(v), 32'(rom_fn(5, 0, 1)));
    read_px(50, 103, v); check("l50 px103 transparent", 32'(v), 32'd9);
    read_px(50, 130, v); check("l50 px130", 32'(v), 32'(rom_fn(5, 0, 30)));
    read_px(50, 132, v); check("l50 px132 bg", 32'(v), 32'd9);
    render_line(49, 4'd2);
    read_px(49, 100, v); check("l49 px100 bg", 32'(v), 32'd2);
    render_line(81, 4'd2);
    read_px(81, 100, v); check("l81 last row", 32'(v), 32'(rom_fn(5, 31, 0)));
    render_line(82, 4'd2);
    read_px(82, 100, v); check("l82 below sprite", 32'(v), 32'd2);
    check("overflow after single", 32'(line_overflow), 32'd0);

    // Right-edge clip, no wrap
    host_write(4'd0, entry_word(0, 2, 60, 620));
    host_write(4'd1, 32'd1);
    vblank_tick();
    render_line(60, 4'd1);
    read_px(60, 620, v); check("clip px620", 32'(v), 32'(rom_fn(2, 0, 0)));
    read_px(60, 638, v); check("clip px638", 32'(v), 32'(rom_fn(2, 0, 18)));
    read_px(60, 639, v); check("clip px639 transparent", 32'(v), 32'd1);
    read_px(60, 0, v);   check("clip no wrap px0", 32'(v), 32'd1);
    read_px(60, 4, v);   check("clip no wrap px4", 32'(v), 32'd1);

    // 17 sprites on line 200: budget of 16
    for (int i = 0; i < 17; i++)
      host_write(4'd0, entry_word(i, i + 1, 200, 32*i));
    host_write(4'd1, 32'd1);
    vblank_tick();
    render_line(200, 4'd13);
    read_px(200, 0, v);   check("ovf idx0", 32'(v), 32'(rom_fn(1, 0, 0)));
    read_px(200, 481, v); check("ovf idx15", 32'(v), 32'(rom_fn(16, 0, 1)));
    read_px(200, 512, v); check("ovf idx16 absent", 32'(v), 32'd13);
    check("overflow set", 32'(line_overflow), 32'd1);
    host_write(4'd2, 32'd0);
    check("overflow cleared", 32'(line_overflow), 32'd0);

    // Back-bank writes without commit leave display alone
    host_write(4'd0, entry_word(0, 9, 10, 300));
    host_write(4'd0, entry_word(1, 3, 0, 0));
    vblank_tick();
    render_line(200, 4'd13);
    read_px(200, 0, v); check("no commit old table", 32'(v), 32'(rom_fn(1, 0, 0)));
    render_line(10, 4'd11);
    read_px(10, 300, v); check("no commit new absent", 32'(v), 32'd11);
    @(negedge clk); vcount = 10'd300;
    host_write(4'd1, 32'd1);
    render_line(200, 4'd13);
    read_px(200, 0, v); check("commit waits vblank", 32'(v), 32'(rom_fn(1, 0, 0)));
    vblank_tick();
    render_line(10, 4'd11);
    read_px(10, 300, v); check("swap new entry", 32'(v), 32'(rom_fn(9, 0, 0)));
    read_px(10, 5, v);   check("swap idx1 row10", 32'(v), 32'(rom_fn(3, 10, 5)));
    render_line(0, 4'd11);
    read_px(0, 0, v);    check("line0 new table", 32'(v), 32'(rom_fn(3, 0, 0)));
    host_write(4'd2, 32'd0);
    check("collision none yet", 32'(collision), 32'd0);

    // Indices 3 and 7 overlap; idx10 reaches line 240
    host_write(4'd0, entry_word(3, 4, 100, 50));
    host_write(4'd0, entry_word(7, 8, 100, 60));
    host_write(4'd0, entry_word(10, 6, 230, 400));
    host_write(4'd1, 32'd1);
    vblank_tick();
    render_line(100, 4'd5);
    read_px(100, 60, v); check("overlap higher wins", 32'(v), 32'(rom_fn(8, 0, 0)));
    read_px(100, 55, v); check("overlap low only", 32'(v), 32'(rom_fn(4, 0, 5)));
    read_px(100, 63, v); check("overlap transparent top", 32'(v), 32'(rom_fn(4, 0, 13)));
    check("collision flag", 32'(collision), 32'(EXP_COLL));
    host_write(4'd2, 32'd0);
    check("collision cleared", 32'(collision), 32'd0);
    @(negedge clk); vcount = 10'd100; hcount = 11'd1300;
    @(negedge clk); check("hblank zero", 32'(pix_color), 32'd0);
    vcount = 10'd480; hcount = 11'd121;
    @(negedge clk); check("vblank zero", 32'(pix_color), 32'd0);

    // Reset in the middle of drawing line 240
    @(negedge clk);
    vcount = 10'd239; hcount = 11'd0;
    for (int h = 1; h <= 40; h++) begin
      @(negedge clk);
      hcount = 11'(h);
    end
    check("mid draw rom_id", 32'(rom_id), 32'd6);
    check("mid draw rom_line", 32'(rom_line), 32'd10);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; hcount = 11'd1000; vcount = 10'd240;
    check("mid reset pix_color", 32'(pix_color), 32'd0);
    check("mid reset overflow", 32'(line_overflow), 32'd0);
    check("mid reset collision", 32'(collision), 32'd0);
    check("mid reset rom_id", 32'(rom_id), 32'd0);
    read_px(240, 400, v); check("mid reset buffer", 32'(v), 32'd0);
    render_line(240, 4'd7);
    read_px(240, 400, v); check("post reset bg only", 32'(v), 32'd7);
    host_write(4'd1, 32'd1);
    vblank_tick();
    render_line(100, 4'd5);
    read_px(100, 60, v); check("post reset bank1 empty", 32'(v), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_line_engine.md
Name: sprite_line_engine

Overview:
- Parametrised successor to the current single-table scanline sprite renderer.
- Double-banked sprite table: host writes a back bank, and the banks swap at start of vblank (tear-free).
- Ping-pong line buffers; per-line sprite budget with sticky overflow flag.
- Sits between the Avalon slave, vga_counters (hcount/vcount), the sprite ROM (sprites), and the palette; outputs a per-pixel colour code.

Parameters:
- NUM_SPRITES, 64: table entries per bank (power of 2, ≤64)
- SPRITE_W, 32: sprite width in pixels
- SPRITE_H, 32: sprite height in lines
- ID_BITS, 6: sprite id width; id 0 = empty
- COLOR_BITS, 4: colour code width; code 0 = transparent
- H_ACTIVE, 640: visible pixels per line
- V_ACTIVE, 480: visible lines
- V_TOTAL, 525: total lines per frame
- MAX_PER_LINE, 16: sprites drawn per line before overflow

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- chipselect  in  1  Avalon chip select
- write  in  1  Avalon write strobe
- address  in  4  Avalon word address
- writedata  in  32  Avalon write data
- hcount  in  11  from vga_counters; pixel column = hcount[10:1]
- vcount  in  10  from vga_counters
- bg_color  in  COLOR_BITS  fill colour for the line being rendered
- rom_id  out  ID_BITS  sprite ROM id
- rom_line  out  clog2(SPRITE_H)  sprite ROM row
- rom_pixel  out  clog2(SPRITE_W)  sprite ROM column
- rom_color  in  COLOR_BITS  ROM data, valid 1 cycle after address
- pix_color  out  COLOR_BITS  colour code to palette
- line_overflow  out  1  sticky: per-line budget exceeded
- collision  out  1  sticky: sprite-on-sprite pixel (optional feature)

Behaviour:
- Register map:
  - addr 0: entry write into back bank. Fields: [31:26] index, [25:20] id, [19:10] y, [9:0] x. Sets the entry's back-bank valid bit. Index ≥ NUM_SPRITES is ignored.
  - addr 1: bit0 = commit request (sets commit_pending).
  - addr 2: write any value to clear line_overflow and collision.
  - Other addresses ignored.
- Bank swap:
  - Happens on the cycle vcount==V_ACTIVE && hcount==0 if commit_pending.
  - Flips the active bank, clears commit_pending, and clears every valid bit of the new back bank; host rewrites the full table each frame.
  - An entry write in the same cycle as the swap lands in the new back bank.
- Target line T = (vcount==V_TOTAL-1) ? 0 : vcount+1.
  - Rendering starts at hcount==0 when T < V_ACTIVE.
  - Writes buffer T[0]; display reads buffer vcount[0].
- FSM states: IDLE, CLEAR, FETCH, CHECK, DRAW, DRAIN.
  - IDLE → CLEAR on the start condition.
  - CLEAR: 1 cycle; every entry of the write buffer = bg_color; index=0, drawn=0.
  - FETCH: 1 cycle; table read, data valid next cycle.
  - CHECK:
    - Skip if the entry is invalid, id==0, T<y, or T-y ≥ SPRITE_H.
    - Skip if drawn==MAX_PER_LINE; in that case also set line_overflow.
    - Otherwise go to DRAW, pixel=0, drawn+=1.
    - On skip: index+1 → FETCH, or → IDLE after NUM_SPRITES-1.
  - DRAW: SPRITE_W cycles issuing rom_pixel 0..SPRITE_W-1.
  - DRAIN: 1 cycle for the last ROM beat; then next index or IDLE.
- Pixel write: 1 cycle after issue; x + pixel computed in 11 bits.
  - Written only if rom_color ≠ 0 and x + pixel < H_ACTIVE (clip, no wrap).
  - Higher index overwrites lower.
- Worst-case cycles: 1 + 2·NUM_SPRITES + MAX_PER_LINE·(SPRITE_W+1) ≤ 1599, checked by elaboration assertion.
  - If the FSM is not in IDLE when hcount==1599, abort to IDLE and set line_overflow.
- Output: pix_color registered (1-cycle latency) = buffer[vcount[0]][hcount[10:1]] when hcount < 2·H_ACTIVE and vcount < V_ACTIVE, else 0.
- Reset values (also apply mid-frame reset; the engine resumes at the next hcount==0):
  - FSM = IDLE, active bank = 0, commit_pending = 0, all valid bits = 0.
  - Both line buffers = 0, pix_color = 0, line_overflow = 0, collision = 0.
  - rom_id / rom_line / rom_pixel = 0.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- Defined:
  - Adds a 1-bit "owned" flag per write-buffer pixel, cleared in CLEAR.
  - A non-transparent write to an owned pixel sets collision (sticky until addr 2 write); every sprite write sets owned.
- Undefined: no owned flags; collision tied to 0.

Decomposition:
- Package sprite_line_pkg:
  - sprite_entry_t struct (x, y, id).
  - Register address constants REG_ENTRY / REG_CTRL / REG_CLR.
  - FSM state enum.
  - Field bit-position localparams.
- Sub-module sprite_table_banks: two twoportbram-based banks plus valid vectors, with swap/clear logic.

Test Plan:
- Entry idx 0, id 5, x 100, y 50, commit, next frame → line 50 pixels 100..131 show ROM codes, code-0 pixels show bg_color; line 49 all background.
- Entry x 620 → pixels 620..639 drawn; no writes to pixels 0..11; no wrap.
- 17 overlapping entries on line 200 with MAX_PER_LINE=16 → indices 0..15 drawn, 16 absent, line_overflow=1 until addr 2 write.
- Entries written without commit → display unchanged; commit at vcount 300 → swap only at vcount 480/hcount 0; frame shows new table from line 0.
- Indices 3 and 7 overlapping → index 7 colour visible; with SPRITE_COLLISION_EN collision=1, without it collision=0.
- Reset asserted at vcount 240 mid-DRAW → pix_color 0, flags 0, all entries invalid; after reset only the background renders.
